// File: rtl/multicycle_processor.sv
// multicycle_processor: 16-bit-instruction multi-cycle CPU with an 8-entry register file, data memory
// and a FETCH/DECODE/EXEC/MEM/WB state machine. One instruction is in flight at a time.
//
// Parameters: DATA_W (word width, >= 8), PC_W (program counter width), DMEM_DEPTH (data words,
// power of two).
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   imem_addr    instruction fetch address (always equals pc)
//   imem_data    instruction word, combinational from imem_addr
//   dbg_addr     register-file debug read index
//   dbg_data     combinational read of register dbg_addr
//   pc           current program counter
//   alu_result   registered ALU output of the last EXEC that used the ALU
//   zero_flag    registered, alu_result == 0
//   retire       one-cycle pulse in the final cycle of each instruction
//   halted       high while in HALT state
//
// Optional feature: define PROC_MUL_EN to make R-type funct 6 a MUL (low DATA_W bits, unsigned);
// without it funct 6 behaves as a NOP.
//
// alu_result/zero_flag are updated only by instructions that use the ALU: defined R-type ops,
// ADDI, LW/SW (effective address) and BEQ (rs - rt). J, HALT, NOP and undefined funct codes leave
// them unchanged.
module multicycle_processor #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned PC_W       = 8,
  parameter int unsigned DMEM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero_flag,
  output logic              retire,
  output logic              halted
);

  localparam int unsigned DaddrW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  state_e            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] rf   [8];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  // Instruction fields
  logic [2:0]        opcode, rs, rt, rd;
  logic [3:0]        funct;
  logic [DATA_W-1:0] imm_data;
  logic [PC_W-1:0]   imm_pc;
  logic [PC_W-1:0]   jaddr;

  assign opcode   = ir[15:13];
  assign rs       = ir[12:10];
  assign rt       = ir[9:7];
  assign rd       = ir[6:4];
  assign funct    = ir[3:0];
  assign imm_data = {{(DATA_W-7){ir[6]}}, ir[6:0]};
  assign imm_pc   = PC_W'($signed(ir[6:0]));
  assign jaddr    = PC_W'(ir[12:0]);

  logic is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_halt;
  logic funct_ok, r_valid, alu_upd, multi_exec;

  always_comb begin
    is_r     = (opcode == 3'b000);
    is_addi  = (opcode == 3'b001);
    is_lw    = (opcode == 3'b010);
    is_sw    = (opcode == 3'b011);
    is_beq   = (opcode == 3'b100);
    is_j     = (opcode == 3'b101);
    is_halt  = (opcode == 3'b110);
    funct_ok = (funct <= 4'd5);
`ifdef PROC_MUL_EN
    if (funct == 4'd6) funct_ok = 1'b1;
`endif
    r_valid    = is_r && funct_ok;
    // Instructions that continue past EXEC
    multi_exec = r_valid || is_addi || is_lw || is_sw;
    alu_upd    = multi_exec || is_beq;
  end

  logic [DATA_W-1:0] alu_out;

  always_comb begin
    alu_out = '0;
    if (is_r) begin
      case (funct)
        4'd0:    alu_out = reg_a + reg_b;
        4'd1:    alu_out = reg_a - reg_b;
        4'd2:    alu_out = reg_a & reg_b;
        4'd3:    alu_out = reg_a | reg_b;
        4'd4:    alu_out = DATA_W'($signed(reg_a) < $signed(reg_b));
        4'd5:    alu_out = reg_a ^ reg_b;
`ifdef PROC_MUL_EN
        4'd6:    alu_out = reg_a * reg_b;
`endif
        default: alu_out = '0;
      endcase
    end else if (is_beq) begin
      alu_out = reg_a - reg_b;
    end else begin
      alu_out = reg_a + imm_data;
    end
  end

  logic [DaddrW-1:0] daddr;
  logic [2:0]        dest;
  logic [DATA_W-1:0] wb_data;

  // alu_result holds the effective address from EXEC; upper bits wrap away
  assign daddr     = alu_result[DaddrW-1:0];
  assign dest      = (is_addi || is_lw) ? rt : rd;
  assign wb_data   = is_lw ? mdr : alu_result;
  assign imem_addr = pc;
  assign dbg_data  = rf[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StFetch;
      pc         <= '0;
      ir         <= '0;
      reg_a      <= '0;
      reg_b      <= '0;
      mdr        <= '0;
      alu_result <= '0;
      zero_flag  <= 1'b1;
      retire     <= 1'b0;
      halted     <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) rf[i] <= '0;
      for (int unsigned i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        StFetch: begin
          ir    <= imem_data;
          pc    <= pc + 1'b1;
          state <= StDecode;
        end
        StDecode: begin
          reg_a  <= rf[rs];
          reg_b  <= rf[rt];
          state  <= StExec;
          // EXEC is the final state for branch/jump/NOP/HALT
          retire <= !multi_exec;
        end
        StExec: begin
          if (alu_upd) begin
            alu_result <= alu_out;
            zero_flag  <= (alu_out == '0);
          end
          if (is_beq && (reg_a == reg_b)) pc <= pc + imm_pc;
          if (is_j) pc <= jaddr;
          if (is_halt) begin
            state  <= StHalt;
            halted <= 1'b1;
          end else if (r_valid || is_addi) begin
            state  <= StWb;
            retire <= 1'b1;
          end else if (is_lw) begin
            state <= StMem;
          end else if (is_sw) begin
            state  <= StMem;
            retire <= 1'b1;
          end else begin
            state <= StFetch;
          end
        end
        StMem: begin
          if (is_lw) begin
            mdr    <= dmem[daddr];
            state  <= StWb;
            retire <= 1'b1;
          end else begin
            dmem[daddr] <= reg_b;
            state       <= StFetch;
          end
        end
        StWb: begin
          if (dest != 3'd0) rf[dest] <= wb_data;
          state <= StFetch;
        end
        StHalt: begin
          state <= StHalt;
        end
        default: begin
          state <= StFetch;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_processor.sv
module tb_multicycle_processor;

  localparam int DW = 16;
  localparam int PW = 8;
  localparam int DD = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] imem_addr;
  logic [15:0]   imem_data;
  logic [2:0]    dbg_addr = 3'd0;
  logic [DW-1:0] dbg_data;
  logic [PW-1:0] pc;
  logic [DW-1:0] alu_result;
  logic          zero_flag;
  logic          retire;
  logic          halted;

  logic [15:0] imem [256];
  always_comb imem_data = imem[imem_addr];

  always #10 clk = ~clk;

  multicycle_processor #(
    .DATA_W     (DW),
    .PC_W       (PW),
    .DMEM_DEPTH (DD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .pc         (pc),
    .alu_result (alu_result),
    .zero_flag  (zero_flag),
    .retire     (retire),
    .halted     (halted)
  );

  int checks   = 0;
  int failures = 0;

  // Architectural reference state
  logic [PW-1:0] m_pc;
  logic [DW-1:0] m_reg  [8];
  logic [DW-1:0] m_dmem [DD];
  logic [DW-1:0] m_alu;
  bit            m_halt;

  int cyc;
  int ret_q[$];

  localparam logic [15:0] NOP  = 16'hE000;
  localparam logic [15:0] HALT = 16'hC000;

  function automatic logic [15:0] enc_r(int rs, int rt, int rd, int fn);
    return {3'b000, 3'(rs), 3'(rt), 3'(rd), 4'(fn)};
  endfunction

  function automatic logic [15:0] enc_i(logic [2:0] op, int rs, int rt, int imm);
    return {op, 3'(rs), 3'(rt), 7'(imm)};
  endfunction

  function automatic logic [15:0] enc_j(int a);
    return {3'b101, 13'(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = NOP;
  endtask

  // Hold reset, check reset state for every register index, release on a negedge
  task automatic do_reset();
    rst    = 1'b1;
    m_pc   = '0;
    m_alu  = '0;
    m_halt = 1'b0;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    for (int i = 0; i < DD; i++) m_dmem[i] = '0;
    cyc = 0;
    ret_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dbg_addr = 3'(i);
      #1;
      chk("rst_pc", pc, 0);
      chk("rst_halted", halted, 0);
      chk("rst_zero", zero_flag, 1);
      chk("rst_retire", retire, 0);
      chk("rst_alu", alu_result, 0);
      chk($sformatf("rst_dbg_r%0d", i), dbg_data, 0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cmp_cycle(input logic [PW-1:0] e_pc, input logic [DW-1:0] e_alu,
                           input logic e_ret, input logic e_halt);
    dbg_addr = 3'($urandom_range(0, 7));
    #1;
    cyc++;
    if (retire === 1'b1) ret_q.push_back(cyc);
    chk("pc", pc, e_pc);
    chk("imem_addr", imem_addr, e_pc);
    chk("retire", retire, e_ret);
    chk("halted", halted, e_halt);
    chk("alu_result", alu_result, e_alu);
    chk("zero_flag", zero_flag, (e_alu == '0));
    chk("dbg_data", dbg_data, m_reg[dbg_addr]);
  endtask

  // Execute one instruction in the model, checking the DUT every cycle it takes.
  // stop_c != 0 asserts rst after the check of that cycle and abandons the instruction.
  task automatic run_instr(input int stop_c);
    logic [15:0]   ins;
    logic [2:0]    op, rs, rt, rd;
    logic [3:0]    fn;
    logic [DW-1:0] a, b, imm, res, wval;
    logic [PW-1:0] npc;
    logic [2:0]    widx;
    int            lat;
    bit            upd, wr, hlt, st;
    ins  = imem[m_pc];
    op   = ins[15:13];
    rs   = ins[12:10];
    rt   = ins[9:7];
    rd   = ins[6:4];
    fn   = ins[3:0];
    a    = m_reg[rs];
    b    = m_reg[rt];
    imm  = {{(DW-7){ins[6]}}, ins[6:0]};
    res  = '0;
    wval = '0;
    widx = rd;
    npc  = m_pc + 8'd1;
    lat  = 3;
    upd  = 0;
    wr   = 0;
    hlt  = 0;
    st   = 0;
    case (op)
      3'd0: begin
        upd = 1; lat = 4; wr = 1;
        case (fn)
          4'd0: res = a + b;
          4'd1: res = a - b;
          4'd2: res = a & b;
          4'd3: res = a | b;
          4'd4: res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
          4'd5: res = a ^ b;
`ifdef PROC_MUL_EN
          4'd6: res = a * b;
`endif
          default: begin upd = 0; lat = 3; wr = 0; end
        endcase
        wval = res;
      end
      3'd1: begin upd = 1; lat = 4; res = a + imm; wr = 1; widx = rt; wval = res; end
      3'd2: begin
        upd = 1; lat = 5; res = a + imm; wr = 1; widx = rt; wval = m_dmem[res[3:0]];
      end
      3'd3: begin upd = 1; lat = 4; res = a + imm; st = 1; end
      3'd4: begin
        upd = 1; res = a - b;
        if (a == b) npc = m_pc + 8'd1 + imm[7:0];
      end
      3'd5: npc = ins[7:0];
      3'd6: hlt = 1;
      default: ;
    endcase
    for (int c = 1; c <= lat; c++) begin
      cmp_cycle((c == 1) ? m_pc : m_pc + 8'd1, (c >= 4 && upd) ? res : m_alu, c == lat, 1'b0);
      if (c == stop_c) begin
        rst = 1'b1;
        return;
      end
      @(negedge clk);
    end
    if (upd) m_alu = res;
    if (wr && widx != 3'd0) m_reg[widx] = wval;
    if (st) m_dmem[res[3:0]] = b;
    m_pc = npc;
    if (hlt) m_halt = 1'b1;
  endtask

  task automatic check_halt(input int n);
    for (int i = 0; i < n; i++) begin
      cmp_cycle(m_pc, m_alu, 1'b0, 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic lit_reg(input int idx, input logic [DW-1:0] exp);
    dbg_addr = 3'(idx);
    #1;
    chk($sformatf("lit_r%0d", idx), dbg_data, exp);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_imem();
    // Directed program: arithmetic, memory with wrap, branch, r0 write, MUL, halt
    imem[0]  = enc_i(3'b001, 0, 1, 5);
    imem[1]  = enc_i(3'b001, 0, 2, -3);
    imem[2]  = enc_r(1, 2, 3, 0);
    imem[3]  = enc_r(2, 1, 4, 1);
    imem[4]  = enc_i(3'b011, 0, 1, 2);
    imem[5]  = enc_i(3'b010, 0, 5, 2);
    imem[6]  = enc_i(3'b010, 0, 6, 18);
    imem[7]  = enc_i(3'b100, 1, 1, 2);
    imem[8]  = enc_i(3'b001, 0, 7, 1);
    imem[9]  = enc_i(3'b001, 0, 7, 1);
    imem[10] = enc_i(3'b001, 0, 0, 9);
    imem[11] = enc_r(1, 1, 7, 6);
    imem[12] = HALT;
    do_reset();
    for (int k = 0; k < 11; k++) run_instr(0);
    check_halt(20);
    lit_reg(0, 16'h0000);
    lit_reg(1, 16'h0005);
    lit_reg(2, 16'hFFFD);
    lit_reg(3, 16'h0002);
    lit_reg(4, 16'hFFF8);
    lit_reg(5, 16'h0005);
    lit_reg(6, 16'h0005);
`ifdef PROC_MUL_EN
    lit_reg(7, 16'd25);
`else
    lit_reg(7, 16'd0);
`endif
    chk("lit_halt_pc", pc, 13);
    chk("lit_retire_count", ret_q.size() >= 7, 1);
    if (ret_q.size() >= 7) begin
      chk("lit_retire0", ret_q[0], 4);
      chk("lit_retire1", ret_q[1], 8);
      chk("lit_retire2", ret_q[2], 12);
      chk("lit_retire3", ret_q[3], 16);
      chk("lit_retire_sw", ret_q[4], 20);
      chk("lit_retire_lw", ret_q[5], 25);
      chk("lit_retire_lw2", ret_q[6], 30);
    end

    // Reset out of HALT, then J to 254, increment, J 0 at the top address
    do_reset();
    clear_imem();
    imem[0]   = enc_j(254);
    imem[254] = enc_i(3'b001, 1, 1, 1);
    imem[255] = enc_j(0);
    for (int k = 0; k < 6; k++) run_instr(0);
    chk("lit_j0_pc", pc, 0);
    lit_reg(1, 16'd2);
    // PC increment wrap from 255 to 0
    imem[0]   = enc_j(255);
    imem[255] = enc_i(3'b001, 2, 2, 1);
    for (int k = 0; k < 4; k++) run_instr(0);
    chk("lit_wrap_pc", pc, 0);
    lit_reg(2, 16'd2);

    // Reset during LW MEM
    do_reset();
    clear_imem();
    imem[0] = enc_i(3'b001, 0, 1, 5);
    imem[1] = enc_i(3'b011, 0, 1, 3);
    imem[2] = enc_i(3'b010, 0, 2, 3);
    run_instr(0);
    run_instr(0);
    run_instr(4);
    do_reset();
    imem[0] = enc_i(3'b010, 0, 2, 3);
    run_instr(0);
    run_instr(0);
    lit_reg(2, 16'd0);

    // Reset during SW MEM
    do_reset();
    clear_imem();
    imem[0] = enc_i(3'b001, 0, 1, 5);
    imem[1] = enc_i(3'b011, 0, 1, 4);
    run_instr(0);
    run_instr(4);
    do_reset();
    imem[0] = enc_i(3'b010, 0, 3, 4);
    run_instr(0);
    run_instr(0);
    lit_reg(3, 16'd0);

    // Random programs without HALT
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 256; i++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:13] == 3'b110) w[15:13] = 3'b111;
        // Bias toward ADDI so registers hold varied data
        if ($urandom_range(0, 3) == 0) w[15:13] = 3'b001;
        imem[i] = w;
      end
      for (int k = 0; k < 300; k++) run_instr(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_processor.md
# multicycle_processor

Parametrised multi-cycle successor to the single-cycle 16-bit datapath: owns its program counter, walks each instruction through a FETCH/DECODE/EXEC/MEM/WB state machine, and adds a data memory, load/store, branch, jump and halt. Instructions come from an external combinational instruction memory. Data width is configurable; the 16-bit instruction format is fixed. Sits at the top of the processor hierarchy and replaces the externally-driven-PC datapath.

## Interface
- DATA_W, 16, register/ALU/data-memory word width (≥8)
- PC_W, 8, program counter width; instruction address space 2^PC_W
- DMEM_DEPTH, 16, data memory words (power of two)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  PC_W  instruction fetch address (equals pc)
- imem_data  in  16  instruction word, combinational from imem_addr
- dbg_addr  in  3  register-file debug read index
- dbg_data  out  DATA_W  combinational read of register dbg_addr
- pc  out  PC_W  current program counter
- alu_result  out  DATA_W  registered ALU output of last EXEC
- zero_flag  out  1  registered, alu_result == 0
- retire  out  1  one-cycle pulse on final cycle of each instruction
- halted  out  1  high while in HALT state

## Operation
- Fields: opcode [15:13], rs [12:10], rt [9:7], rd [6:4], funct [3:0], imm7 [6:0] sign-extended to DATA_W, jaddr [12:0].
- 8 registers; r0 reads 0, writes discarded.
- Opcodes: 000 R-type rd=rs op rt (funct 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT signed → 1/0, 5 XOR, others NOP); 001 ADDI rt=rs+imm; 010 LW rt=dmem[rs+imm]; 011 SW dmem[rs+imm]=rt; 100 BEQ if rs==rt pc=pc+1+imm; 101 J pc=jaddr[PC_W-1:0]; 110 HALT; 111 NOP.
- States: FETCH (latch imem_data into IR, pc←pc+1) → DECODE (latch A=reg[rs], B=reg[rt]) → EXEC (ALU; BEQ/J/NOP/HALT finish here) → MEM (LW read, SW write) → WB (register write).
- Paths: R/ADDI: F,D,E,WB. LW: F,D,E,M,WB. SW: F,D,E,M. BEQ/J/NOP/undefined funct: F,D,E. HALT: F,D,E → HALT.
- Arithmetic modulo 2^DATA_W; overflow ignored. BEQ target computed from incremented pc, modulo 2^PC_W.
- Data address = low log2(DMEM_DEPTH) bits of rs+imm; upper bits ignored (wrap).
- PC wraps 2^PC_W−1 → 0 on FETCH.
- HALT: stays until rst; no fetches, pc frozen, retire low.

## Timing
- Reset values: pc=0, state FETCH, all registers 0, all dmem words 0, IR=0, alu_result=0, zero_flag=1, retire=0, halted=0.
- rst dominates any state including mid-MEM; pending SW/WB is cancelled, no write occurs that cycle.
- First FETCH on first cycle after rst deasserts.
- Latency: R/ADDI 4, LW 5, SW 4, BEQ/J/NOP 3 cycles; retire asserted in the last state of each.
- pc updated at end of FETCH; BEQ/J override at end of EXEC.
- Register write at end of WB; write visible to DECODE of the next instruction (no hazards, one instruction in flight).
- dbg_data reflects register write the cycle after WB.
- dmem read in MEM, registered into MDR, written back in WB.

## Configuration
- PROC_MUL_EN defined: R-type funct 6 = MUL, rd = low DATA_W bits of rs×rt (unsigned), 4-cycle path.
- Undefined: funct 6 is a NOP (3-cycle path, no register write).

## Test plan
- Reset: hold rst 2 cycles with imem driven → pc=0, halted=0, dbg_data=0 for all indices, zero_flag=1.
- ADDI r1=r0+5; ADDI r2=r0+−3; ADD r3=r1,r2; SUB r4=r2,r1 → r3=2, r4=0xFFF8 (DATA_W=16), retire pulses at cycles 4,8,12,16.
- SW r1→dmem[r0+2], LW r5←dmem[r0+2], LW r6←dmem[r0+18] (DMEM_DEPTH=16 wrap) → r5=r6=5; LW completes in 5 cycles.
- BEQ r1,r1,+2 skips two instructions; J 0 at pc=2^PC_W−1 and pc increment wrap both land at 0; ADDI to r0 leaves r0=0.
- HALT → halted=1 after 3 cycles, pc constant for 20 cycles; rst asserted during HALT and during LW MEM → clean restart, no dmem/register write.
- MUL r7=r1,r1 → 25 with PROC_MUL_EN; r7 unchanged and 3-cycle retire without.
